pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch.sv | 156 +++++++++++++++
 tb/tb_pc_fetch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// Instruction fetch / single data-access sequencer for a shared memory bus.
// Optional macro PC_FETCH_WAIT_EN compiles in the WAIT_CYCLES wait-state counter.
module pc_fetch #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       WAIT_CYCLES = 0,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              dbg_clk,
  input  logic              rst_n,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_done,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              rw_mem,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DATA  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   daddr_q, daddr_d;
  logic                dwe_q, dwe_d;
  logic [DATA_W-1:0]   dwdata_q, dwdata_d;
  logic                last_c;

`ifdef PC_FETCH_WAIT_EN
  // Counts wait states within a FETCH or DATA access; zero outside an access.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last_c = (cnt_q == WAIT_LAST);

  always_comb begin
    cnt_d = '0;
    if ((state_q == FETCH || state_q == DATA) && !last_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge dbg_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_wait_c;

  assign last_c        = 1'b1;
  assign unused_wait_c = ^(CNT_W'(WAIT_CYCLES));
`endif

  // Next-state and register updates for the fetch/hold/data sequence.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    daddr_d    = daddr_q;
    dwe_d      = dwe_q;
    dwdata_d   = dwdata_q;
    case (state_q)
      FETCH: begin
        if (last_c) begin
          instr_d = mem_rdata;
          pc_d    = fetch_pc_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          fetch_pc_d = jmp ? jmp_addr : pc_q + ADDR_W'(1);
          if (data_req) begin
            daddr_d  = data_addr;
            dwe_d    = data_we;
            dwdata_d = data_wdata;
            state_d  = DATA;
          end else begin
            state_d = FETCH;
          end
        end
      end
      DATA: begin
        if (last_c) begin
          if (!dwe_q) begin
            rdata_d = mem_rdata;
          end
          done_d  = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge dbg_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      daddr_q    <= '0;
      dwe_q      <= 1'b0;
      dwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      daddr_q    <= daddr_d;
      dwe_q      <= dwe_d;
      dwdata_q   <= dwdata_d;
    end
  end

  // Bus controls decode straight from state so reset drops rw_mem immediately.
  assign mem_addr    = (state_q == DATA) ? daddr_q : fetch_pc_q;
  assign rw_mem      = (state_q == DATA) && dwe_q;
  assign mem_wdata   = dwdata_q;
  assign instr_valid = (state_q == HOLD);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign data_rdata  = rdata_q;
  assign data_done   = done_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: expected fetches and data accesses are queued
// at acceptance and checked as the DUT walks through FETCH / DATA / HOLD.
module tb_pc_fetch;

`ifdef PC_FETCH_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] instr;
  } ifetch_t;

  typedef struct packed {
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } dacc_t;

  logic       dbg_clk;
  logic       rst_n;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       jmp;
  logic [7:0] jmp_addr;
  logic       data_req;
  logic       data_we;
  logic [7:0] data_addr;
  logic [7:0] data_wdata;
  logic [7:0] data_rdata;
  logic       data_done;
  logic [7:0] pc;
  logic [7:0] mem_addr;
  logic       rw_mem;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] mem [256];
  ifetch_t    exp_q[$];
  dacc_t      dq[$];
  logic [7:0] cur_pc;
  logic [7:0] cur_instr;
  logic [7:0] last_rdata;
  int         n_vec;
  int         n_err;

  pc_fetch #(
    .DATA_W     (8),
    .ADDR_W     (8),
    .WAIT_CYCLES(2),
    .RESET_PC   (8'h00)
  ) dut (
    .dbg_clk    (dbg_clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .jmp        (jmp),
    .jmp_addr   (jmp_addr),
    .data_req   (data_req),
    .data_we    (data_we),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .data_done  (data_done),
    .pc         (pc),
    .mem_addr   (mem_addr),
    .rw_mem     (rw_mem),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  initial begin
    dbg_clk = 1'b0;
    forever #5 dbg_clk = ~dbg_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fetch_phase();
    int      n = 0;
    ifetch_t e;
    if (exp_q.size() == 0) begin
      chk("fetch_q_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    while (!instr_valid && n < 40) begin
      chk("f_addr", mem_addr, e.pc);
      chk("f_rw", rw_mem, 0);
      n++;
      @(negedge dbg_clk);
      chk("done_once", data_done, 0);
    end
    chk("f_cycles", n, EXP_WAIT + 1);
    chk("h_valid", instr_valid, 1);
    chk("h_pc", pc, e.pc);
    chk("h_instr", instr, e.instr);
    cur_pc    = e.pc;
    cur_instr = e.instr;
  endtask

  task automatic data_phase();
    int    n = 0;
    dacc_t d;
    if (dq.size() == 0) begin
      chk("data_q_empty", 1, 0);
      return;
    end
    d = dq.pop_front();
    while (!data_done && n < 40) begin
      chk("d_addr", mem_addr, d.addr);
      chk("d_rw", rw_mem, d.we);
      if (d.we) chk("d_wdata", mem_wdata, d.wdata);
      chk("d_valid", instr_valid, 0);
      n++;
      @(negedge dbg_clk);
    end
    chk("d_cycles", n, EXP_WAIT + 1);
    chk("d_done_rw", rw_mem, 0);
    chk("d_rdata", data_rdata, d.rdata);
  endtask

  // Accepts the held instruction with the given side requests and follows it through.
  task automatic accept(input logic j, input logic [7:0] ja, input logic dr,
                        input logic dw, input logic [7:0] da, input logic [7:0] dwd);
    logic [7:0] nxt;
    instr_ready = 1'b1;
    jmp         = j;
    jmp_addr    = ja;
    data_req    = dr;
    data_we     = dw;
    data_addr   = da;
    data_wdata  = dwd;
    nxt = j ? ja : 8'(cur_pc + 8'd1);
    exp_q.push_back(ifetch_t'{pc: nxt, instr: mem[nxt]});
    if (dr) begin
      if (!dw) last_rdata = mem[da];
      dq.push_back(dacc_t'{addr: da, we: dw, wdata: dwd, rdata: last_rdata});
    end
    @(negedge dbg_clk);
    instr_ready = 1'b0;
    jmp         = 1'b0;
    data_req    = 1'b0;
    data_we     = 1'b0;
    if (dr) data_phase();
    fetch_phase();
  endtask

  task automatic hold_test(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      instr_ready = 1'b0;
      jmp         = 1'b1;
      jmp_addr    = 8'($urandom);
      data_req    = 1'b1;
      data_we     = 1'b1;
      @(negedge dbg_clk);
      chk("hold_valid", instr_valid, 1);
      chk("hold_pc", pc, cur_pc);
      chk("hold_instr", instr, cur_instr);
      chk("hold_rw", rw_mem, 0);
    end
    jmp      = 1'b0;
    data_req = 1'b0;
    data_we  = 1'b0;
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    last_rdata  = 8'h00;
    cur_pc      = 8'h00;
    cur_instr   = 8'h00;
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    jmp         = 1'b0;
    jmp_addr    = 8'h00;
    data_req    = 1'b0;
    data_we     = 1'b0;
    data_addr   = 8'h00;
    data_wdata  = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 13 + 5);
    mem[8'h00] = 8'hA5;
    mem[8'h20] = 8'h77;
    mem[8'h40] = 8'h5A;
    mem[8'hFF] = 8'hC3;

    repeat (2) @(negedge dbg_clk);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_rw", rw_mem, 0);
    chk("rst_done", data_done, 0);
    chk("rst_rdata", data_rdata, 0);
    chk("rst_addr", mem_addr, 0);

    exp_q.push_back(ifetch_t'{pc: 8'h00, instr: mem[8'h00]});
    rst_n = 1'b1;
    fetch_phase();

    accept(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    accept(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    accept(1'b1, 8'h40, 1'b1, 1'b1, 8'h10, 8'h3C);
    accept(1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    hold_test(5);
    accept(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00);
    accept(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    accept(1'b0, 8'h00, 1'b1, 1'b1, 8'h30, 8'h99);
    accept(1'b1, 8'h80, 1'b1, 1'b0, 8'hFF, 8'h00);

    for (int i = 0; i < 24; i++) begin
      accept(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
    end

    // Reset during a write access.
    instr_ready = 1'b1;
    data_req    = 1'b1;
    data_we     = 1'b1;
    data_addr   = 8'h55;
    data_wdata  = 8'hEE;
    @(negedge dbg_clk);
    instr_ready = 1'b0;
    data_req    = 1'b0;
    data_we     = 1'b0;
    chk("wr_rw_before", rw_mem, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("wr_rw_async", rw_mem, 0);
    chk("wr_rst_valid", instr_valid, 0);
    chk("wr_rst_pc", pc, 0);
    chk("wr_rst_rdata", data_rdata, 0);
    @(negedge dbg_clk);
    chk("wr_rst_done", data_done, 0);
    exp_q.delete();
    dq.delete();
    last_rdata = 8'h00;
    exp_q.push_back(ifetch_t'{pc: 8'h00, instr: mem[8'h00]});
    rst_n = 1'b1;
    fetch_phase();
    accept(1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
